// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the elastic pipeline stage registers.
//               These are the occupancy-state encoding (the encoding equals
//               the number of held entries) and the MIPS nop payload used as
//               the idle value by the CPU instances.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int unsigned STATE_W = 2;

    // The state value is also the entry count, so Occupancy is the state itself.
    localparam logic [STATE_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [STATE_W-1:0] ST_ONE   = 2'd1;
    localparam logic [STATE_W-1:0] ST_TWO   = 2'd2;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot_reg
// Description : One payload slot of the skid stage. This is a WIDTH-bit
//               register with a load and a clear-to-idle-value control.
//               Priority: Reset > clear > load > hold.
// Ports       : Clk, Reset   - clock and synchronous active-high reset
//               clear        - force the slot to NOP_VAL
//               load         - capture d
//               d / q        - payload in / held payload out
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot_reg #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= NOP_VAL;
        end else if (clear) begin
            q <= NOP_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : pipe_slot_reg
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Elastic pipeline stage register with a valid/ready handshake,
//               a 2-entry skid buffer (main + skid slot), flush, and a
//               saturating count of entries discarded by flush.
//               In_Ready is decoded from the registered state only, so no
//               combinational path runs from Out_Ready to In_Ready.
// Ports       : Clk, Reset             - clock, sync active-high reset
//               Flush                  - discard held and incoming entries
//               In_Valid/In_Ready/In_Data    - upstream handshake + payload
//               Out_Valid/Out_Ready/Out_Data - downstream handshake + payload
//               Occupancy              - entries held (0..2)
//               Drop_Count             - saturating flush-drop counter
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] NOP_VAL = WIDTH'(MIPS_NOP),
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] In_Data,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out_Data,
    output logic [1:0]       Occupancy,
    output logic [CNT_W-1:0] Drop_Count
);

    localparam int unsigned        SUM_W    = CNT_W + 2;
    localparam logic [SUM_W-1:0]   DROP_MAX = {2'b00, {CNT_W{1'b1}}};

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;

    logic             in_fire;
    logic             out_fire;

    logic             main_load;
    logic             main_clear;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;

    logic             skid_load;
    logic             skid_clear;
    logic [WIDTH-1:0] skid_q;

    logic [SUM_W-1:0] drop_sum;

    // ------------------------------------------------------------------------
    // Handshake decode from registered state
    // ------------------------------------------------------------------------
    assign In_Ready  = (state != ST_TWO);
    assign Out_Valid = (state != ST_EMPTY);
    assign in_fire   = In_Valid & In_Ready;
    assign out_fire  = Out_Valid & Out_Ready;
    assign Occupancy = state;

    // Main slot is cleared whenever the stage drains, so it already reads
    // NOP_VAL while Out_Valid is low.
    assign Out_Data  = main_q;

    // ------------------------------------------------------------------------
    // Next-state and slot control
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if (Flush) begin
            // Upstream still sees its handshake complete; the beat is dropped.
            state_nxt  = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        // Stage fills; In_Ready drops next cycle.
                        state_nxt = ST_TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_nxt  = ST_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                ST_TWO: begin
                    // In_Ready is low here, so only the drain side can fire.
                    if (out_fire) begin
                        state_nxt      = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_nxt  = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : In_Data;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Payload slots
    // ------------------------------------------------------------------------
    pipe_slot_reg #(
        .WIDTH   (WIDTH),
        .NOP_VAL (NOP_VAL)
    ) u_main_slot (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (main_clear),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_slot_reg #(
        .WIDTH   (WIDTH),
        .NOP_VAL (NOP_VAL)
    ) u_skid_slot (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (skid_clear),
        .load  (skid_load),
        .d     (In_Data),
        .q     (skid_q)
    );

    // ------------------------------------------------------------------------
    // Flush-drop counter. Entries lost = held + accepted - delivered. The
    // subtraction cannot underflow: out_fire implies at least one held entry.
    // ------------------------------------------------------------------------
    assign drop_sum = {2'b00, Drop_Count}
                    + {{CNT_W{1'b0}}, Occupancy}
                    + {{(CNT_W + 1){1'b0}}, in_fire}
                    - {{(CNT_W + 1){1'b0}}, out_fire};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Drop_Count <= '0;
        end else if (Flush) begin
            if (drop_sum > DROP_MAX) begin
                Drop_Count <= {CNT_W{1'b1}};
            end else begin
                Drop_Count <= drop_sum[CNT_W-1:0];
            end
        end
    end

endmodule : pipe_stage_skid
`default_nettype wire
